// File: rtl/xalu_seq_if.sv
// Request/result handshake bundle for xalu_seq: operands and function code in,
// accumulator and flags out, each side with its own valid/ready pair.
interface xalu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       fn;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             use_acc;
   logic             com;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_c;
   logic             flag_z;
   logic             flag_nz;
   logic             flag_eq;

   modport master (
      output in_valid, fn, a, b, use_acc, com, out_ready,
      input  in_ready, out_valid, result, flag_c, flag_z, flag_nz, flag_eq
   );

   modport slave (
      input  in_valid, fn, a, b, use_acc, com, out_ready,
      output in_ready, out_valid, result, flag_c, flag_z, flag_nz, flag_eq
   );
endinterface

// File: rtl/xalu_seq.sv
// Registered xalu slice: WIDTH-bit accumulator, carry chain, valid/ready handshake, iterative shifts.
// Define XALU_ROTATE_EN to build ROLN/RORN (fn 13/14); without it those codes behave as NOP.
module xalu_seq #(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   xalu_seq_if.slave  bus
);
   localparam int SW = $clog2(WIDTH);

   typedef enum logic [3:0] {
      FN_ADD  = 4'd0,  FN_ADC  = 4'd1,  FN_SUB  = 4'd2,  FN_SBC  = 4'd3,
      FN_AND  = 4'd4,  FN_OR   = 4'd5,  FN_XOR  = 4'd6,  FN_PASA = 4'd7,
      FN_PASB = 4'd8,  FN_SHL1 = 4'd9,  FN_SHR1 = 4'd10, FN_SHLN = 4'd11,
      FN_SHRN = 4'd12, FN_ROLN = 4'd13, FN_RORN = 4'd14, FN_NOP  = 4'd15
   } fn_e;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

   state_e           state;
   logic [SW-1:0]    count;
   logic [WIDTH-1:0] sh_reg;
   fn_e              sh_fn;
   logic             sh_com;
   logic             sh_eq;

   logic [WIDTH-1:0] result_q;
   logic             flag_c_q, flag_z_q, flag_nz_q, flag_eq_q, out_valid_q;

   logic [WIDTH-1:0] op_a, op_b, raw, stored, sh_next, fin;
   logic [WIDTH:0]   sum;
   logic [SW-1:0]    n;
   logic             raw_c, arith, upd, iter_fn, start, ready, accept, last, done, sh_out;

   assign ready  = (state == IDLE) & (~out_valid_q | bus.out_ready);
   assign accept = bus.in_valid & ready;
   assign last   = (state == SHIFT) && (count == SW'(1));
   assign done   = (accept & ~start) | last;
   assign stored = bus.com ? ~raw : raw;
   assign fin    = sh_com ? ~sh_next : sh_next;

   // NOTE: every signal gets a default at the top of the block so no path leaves
   // it unassigned; a missing default would infer a latch.
   always_comb begin
      op_a    = bus.use_acc ? result_q : bus.a;
      op_b    = bus.b;
      n       = bus.b[SW-1:0];
      sum     = '0;
      raw     = result_q;
      raw_c   = flag_c_q;
      arith   = 1'b0;
      upd     = 1'b1;
      iter_fn = 1'b0;
      start   = 1'b0;
      case (fn_e'(bus.fn))
         FN_ADD: begin arith = 1'b1; sum = {1'b0, op_a} + {1'b0, op_b}; end
         FN_ADC: begin arith = 1'b1; sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, flag_c_q}; end
         FN_SUB: begin arith = 1'b1; sum = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1}; end
         FN_SBC: begin arith = 1'b1; sum = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, flag_c_q}; end
         FN_AND:  raw = op_a & op_b;
         FN_OR:   raw = op_a | op_b;
         FN_XOR:  raw = op_a ^ op_b;
         FN_PASA: raw = op_a;
         FN_PASB: raw = op_b;
         FN_SHL1: begin raw = {op_a[WIDTH-2:0], flag_c_q}; raw_c = op_a[WIDTH-1]; end
         FN_SHR1: begin raw = {flag_c_q, op_a[WIDTH-1:1]}; raw_c = op_a[0]; end
         FN_SHLN, FN_SHRN: iter_fn = 1'b1;
         FN_ROLN, FN_RORN: begin
`ifdef XALU_ROTATE_EN
            iter_fn = 1'b1;
`else
            upd = 1'b0;
`endif
         end
         default: upd = 1'b0;
      endcase
      if (arith) begin
         raw   = sum[WIDTH-1:0];
         raw_c = sum[WIDTH];
      end
      // A zero count completes at once with A passed through and carry untouched.
      if (iter_fn) begin
         raw = op_a;
         if (n != '0) begin
            upd   = 1'b0;
            start = 1'b1;
         end
      end
   end

   always_comb begin
      sh_next = sh_reg;
      sh_out  = 1'b0;
      case (sh_fn)
         FN_SHLN: begin sh_next = {sh_reg[WIDTH-2:0], 1'b0}; sh_out = sh_reg[WIDTH-1]; end
         FN_SHRN: begin sh_next = {1'b0, sh_reg[WIDTH-1:1]}; sh_out = sh_reg[0]; end
`ifdef XALU_ROTATE_EN
         FN_ROLN: begin sh_next = {sh_reg[WIDTH-2:0], sh_reg[WIDTH-1]}; sh_out = sh_reg[WIDTH-1]; end
         FN_RORN: begin sh_next = {sh_reg[0], sh_reg[WIDTH-1:1]}; sh_out = sh_reg[0]; end
`endif
         default: ;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         sh_reg      <= '0;
         sh_fn       <= FN_NOP;
         sh_com      <= 1'b0;
         sh_eq       <= 1'b0;
         result_q    <= '0;
         flag_c_q    <= 1'b0;
         flag_z_q    <= 1'b1;
         flag_nz_q   <= 1'b0;
         flag_eq_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept && start) begin
                  state  <= SHIFT;
                  count  <= n;
                  sh_reg <= op_a;
                  sh_fn  <= fn_e'(bus.fn);
                  sh_com <= bus.com;
                  sh_eq  <= (op_a == op_b);
               end else if (accept && upd) begin
                  result_q  <= stored;
                  flag_c_q  <= raw_c;
                  flag_z_q  <= (stored == '0);
                  flag_nz_q <= &stored;
                  flag_eq_q <= (op_a == op_b);
               end
            end
            SHIFT: begin
               sh_reg <= sh_next;
               count  <= count - SW'(1);
               // The working register stays private until the final bit moves.
               if (last) begin
                  state     <= IDLE;
                  result_q  <= fin;
                  flag_c_q  <= sh_out;
                  flag_z_q  <= (fin == '0);
                  flag_nz_q <= &fin;
                  flag_eq_q <= sh_eq;
               end
            end
         endcase
         if (done)
            out_valid_q <= 1'b1;
         else if (bus.out_ready)
            out_valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flag_c    = flag_c_q;
   assign bus.flag_z    = flag_z_q;
   assign bus.flag_nz   = flag_nz_q;
   assign bus.flag_eq   = flag_eq_q;
endmodule

// File: tb/tb_xalu_seq.sv
// Self-checking bench for xalu_seq (WIDTH=8): directed scenarios plus random ops
// compared against an arithmetic reference model of the accumulator and flags.
module tb_xalu_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   xalu_seq_if #(.WIDTH(8)) bus();

   xalu_seq #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] m_acc = 8'h00;
   bit         m_c   = 1'b0;
   bit         m_eq  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 8'h00;
      m_c   = 1'b0;
      m_eq  = 1'b0;
   endtask

   // Reference: plain integer arithmetic on the architectural rules.
   task automatic model_op(input logic [3:0] f, input logic [7:0] av, input logic [7:0] bv,
                           input logic ua, input logic cm, output int lat);
      int A, B, r, n;
      bit c, upd;
      A = ua ? int'(m_acc) : int'(av);
      B = int'(bv);
      n = B % 8;
      r = 0;
      c = m_c;
      upd = 1'b1;
      lat = 0;
      case (f)
         4'd0:  r = A + B;
         4'd1:  r = A + B + int'(m_c);
         4'd2:  r = A + (255 - B) + 1;
         4'd3:  r = A + (255 - B) + int'(m_c);
         4'd4:  r = A & B;
         4'd5:  r = A | B;
         4'd6:  r = A ^ B;
         4'd7:  r = A;
         4'd8:  r = B;
         4'd9:  begin r = (A * 2) % 256 + int'(m_c); c = (A >= 128); end
         4'd10: begin r = A / 2 + 128 * int'(m_c); c = (A % 2) == 1; end
         4'd11: begin r = (A << n) % 256; lat = n; if (n != 0) c = ((A >> (8 - n)) % 2) == 1; end
         4'd12: begin r = A >> n; lat = n; if (n != 0) c = ((A >> (n - 1)) % 2) == 1; end
`ifdef XALU_ROTATE_EN
         4'd13: begin r = ((A << n) | (A >> (8 - n))) % 256; lat = n; if (n != 0) c = (r % 2) == 1; end
         4'd14: begin r = ((A >> n) | (A << (8 - n))) % 256; lat = n; if (n != 0) c = (r >= 128); end
`endif
         default: upd = 1'b0;
      endcase
      if (f <= 4'd3) begin
         c = (r > 255);
         r = r % 256;
      end
      if (upd) begin
         m_acc = 8'(cm ? 255 - r : r);
         m_c   = c;
         m_eq  = (A == B);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_res"}, bus.result, m_acc);
      check({tag, "_c"},   bus.flag_c, m_c);
      check({tag, "_z"},   bus.flag_z, m_acc == 8'h00);
      check({tag, "_nz"},  bus.flag_nz, m_acc == 8'hFF);
      check({tag, "_eq"},  bus.flag_eq, m_eq);
   endtask

   // Called at a negedge; returns at the negedge where out_valid is seen.
   task automatic send(input logic [3:0] f, input logic [7:0] av, input logic [7:0] bv,
                       input logic ua, input logic cm, input string tag);
      int lat, cyc, busy, k;
      bus.fn = f; bus.a = av; bus.b = bv; bus.use_acc = ua; bus.com = cm;
      bus.in_valid = 1'b1;
      k = 0;
      while (!bus.in_ready && k < 40) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_accept"}, bus.in_ready, 1);
      model_op(f, av, bv, ua, cm, lat);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      cyc = 0;
      busy = 0;
      while (!bus.out_valid && cyc < 40) begin
         if (!bus.in_ready) busy++;
         @(negedge clk);
         cyc++;
      end
      check({tag, "_ovalid"}, bus.out_valid, 1);
      check({tag, "_lat"}, cyc, lat);
      check({tag, "_busy"}, busy, lat);
      check_state(tag);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0] f;
      logic [7:0] av, bv;
      logic       ua, cm;
      int         lat;

      bus.in_valid = 1'b0; bus.fn = 4'd15; bus.a = '0; bus.b = '0;
      bus.use_acc = 1'b0; bus.com = 1'b0; bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_res", bus.result, 8'h00);
      check("rst_c", bus.flag_c, 0);
      check("rst_z", bus.flag_z, 1);
      check("rst_nz", bus.flag_nz, 0);
      check("rst_eq", bus.flag_eq, 0);
      check("rst_ovalid", bus.out_valid, 0);
      check("rst_iready", bus.in_ready, 1);

      // Reset lands in the middle of a 5-step shift.
      bus.fn = 4'd11; bus.a = 8'h81; bus.b = 8'd5; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("midshift_busy", bus.in_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_res", bus.result, 8'h00);
      check("abort_z", bus.flag_z, 1);
      check("abort_ovalid", bus.out_valid, 0);
      check("abort_iready", bus.in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (6) @(negedge clk);
      check("abort_quiet_ovalid", bus.out_valid, 0);
      check("abort_quiet_res", bus.result, 8'h00);

      send(4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, "add");
      check("plan_add_res", bus.result, 8'h00);
      check("plan_add_c", bus.flag_c, 1);
      send(4'd1, 8'h00, 8'h00, 1'b1, 1'b0, "adc");
      check("plan_adc_res", bus.result, 8'h01);
      check("plan_adc_c", bus.flag_c, 0);
      send(4'd2, 8'h05, 8'h07, 1'b0, 1'b0, "sub");
      check("plan_sub_res", bus.result, 8'hFE);
      send(4'd7, 8'h00, 8'h00, 1'b0, 1'b1, "pasa_com");
      check("plan_pasa_nz", bus.flag_nz, 1);
      send(4'd11, 8'h81, 8'd3, 1'b0, 1'b0, "shln3");
      check("plan_shln_res", bus.result, 8'h08);
      send(4'd12, 8'h81, 8'd0, 1'b0, 1'b0, "shrn0");
      check("plan_shrn0_res", bus.result, 8'h81);
      send(4'd14, 8'h01, 8'd1, 1'b0, 1'b0, "rorn1");
`ifdef XALU_ROTATE_EN
      check("plan_rorn_res", bus.result, 8'h80);
`else
      check("plan_rorn_res", bus.result, 8'h81);
`endif

      // Backpressure: a pending request must wait for the consumer.
      @(negedge clk);
      bus.out_ready = 1'b0;
      send(4'd0, 8'h10, 8'h22, 1'b0, 1'b0, "bp_add");
      bus.fn = 4'd6; bus.a = 8'hF0; bus.b = 8'h0F; bus.use_acc = 1'b0; bus.com = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("bp_iready", bus.in_ready, 0);
         @(negedge clk);
         check("bp_held_res", bus.result, 8'h32);
         check("bp_held_ovalid", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_release_iready", bus.in_ready, 1);
      model_op(4'd6, 8'hF0, 8'h0F, 1'b0, 1'b0, lat);
      @(posedge clk);
      #1;
      check("bp_swap_ovalid", bus.out_valid, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("bp_new_ovalid", bus.out_valid, 1);
      check_state("bp_xor");

      // Back-to-back single-cycle ops with the consumer always ready.
      for (int i = 0; i < 10; i++) begin
         f = 4'($urandom_range(0, 10));
         av = 8'($urandom); bv = 8'($urandom);
         ua = ($urandom_range(0, 2) == 0); cm = ($urandom_range(0, 4) == 0);
         bus.fn = f; bus.a = av; bus.b = bv; bus.use_acc = ua; bus.com = cm;
         bus.in_valid = 1'b1;
         check("b2b_iready", bus.in_ready, 1);
         model_op(f, av, bv, ua, cm, lat);
         @(posedge clk);
         @(negedge clk);
         check("b2b_ovalid", bus.out_valid, 1);
         check_state("b2b");
      end
      bus.in_valid = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 150; i++) begin
         f = 4'($urandom_range(0, 15));
         av = 8'($urandom); bv = 8'($urandom);
         ua = ($urandom_range(0, 3) == 0); cm = ($urandom_range(0, 4) == 0);
         send(f, av, bv, ua, cm, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
